lsu_load_aligner: RTL and testbench

Load-return path of the LSU, the counterpart to address generation. For each issued load it records the low address bits, size, signedness and destination register. It then pairs in-order D-cache responses with those records, extracts and sign/zero-extends the addressed bytes from the 64-bit response word, and presents a registered writeback to the register file. It sits between the D-cache response port and the integer writeback arbiter.

---
 rtl/lsu_load_aligner.sv | 155 +++++++++++++++
 tb/tb_lsu_load_aligner.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_load_aligner.sv
// Load-return aligner: queues per-load access records, pairs them with in-order
// D-cache responses, extracts/extends the addressed bytes and registers the writeback.
module lsu_load_aligner #(
   parameter int XLEN   = 64,
   parameter int DEPTH  = 4,
   parameter int PREG_W = 6
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        req_offset_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [PREG_W-1:0] req_rd_i,
   input  logic              resp_valid_i,
   input  logic [XLEN-1:0]   resp_data_i,
   output logic              resp_ready_o,
   output logic              wb_valid_o,
   input  logic              wb_ready_i,
   output logic [PREG_W-1:0] wb_rd_o,
   output logic [XLEN-1:0]   wb_data_o,
   output logic              wb_misalign_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [2:0]        offset;
      logic [1:0]        size;
      logic              is_unsigned;
      logic [PREG_W-1:0] rd;
      logic              misalign;
   } entry_t;

   entry_t            entry_reg [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;

   logic              wb_valid_reg;
   logic [PREG_W-1:0] wb_rd_reg;
   logic [XLEN-1:0]   wb_data_reg;
   logic              wb_misalign_reg;

   entry_t            head;
   entry_t            new_entry;
   logic              req_misalign;
   logic              not_empty;
   logic              out_free;
   logic              enq;
   logic              deq_aligned;
   logic              deq_misalign;
   logic              deq;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   extended;

   // Misalignment is decided once at issue so the head check is a single bit.
   always_comb begin
      req_misalign = 1'b0;
      case (req_size_i)
         2'd0:    req_misalign = 1'b0;
         2'd1:    req_misalign = req_offset_i[0];
         2'd2:    req_misalign = (req_offset_i[1:0] != 2'b00);
         default: req_misalign = (req_offset_i != 3'b000);
      endcase
   end

   assign new_entry = '{offset:      req_offset_i,
                        size:        req_size_i,
                        is_unsigned: req_unsigned_i,
                        rd:          req_rd_i,
                        misalign:    req_misalign};

   assign head        = entry_reg[rd_ptr_reg];
   assign not_empty   = (count_reg != '0);
   assign out_free    = !wb_valid_reg || wb_ready_i;

   // Full check uses count alone, so a same-cycle dequeue never frees a slot early.
   assign req_ready_o  = (count_reg != CNT_W'(DEPTH));
   assign enq          = req_valid_i && req_ready_o && !flush_i;
   assign resp_ready_o = not_empty && !head.misalign && out_free && !flush_i;
   assign deq_aligned  = resp_valid_i && resp_ready_o;
   assign deq_misalign = not_empty && head.misalign && out_free && !flush_i;
   assign deq          = deq_aligned || deq_misalign;

   assign shifted = resp_data_i >> {head.offset, 3'b000};

   always_comb begin
      extended = shifted;
      case (head.size)
         2'd0:    extended = {{(XLEN-8){!head.is_unsigned && shifted[7]}}, shifted[7:0]};
         2'd1:    extended = {{(XLEN-16){!head.is_unsigned && shifted[15]}}, shifted[15:0]};
         2'd2:    extended = {{(XLEN-32){!head.is_unsigned && shifted[31]}}, shifted[31:0]};
         default: extended = shifted;
      endcase
   end

   // Record storage carries no reset; validity is tracked by count_reg alone.
   always_ff @(posedge clk) begin
      if (enq) begin
         entry_reg[wr_ptr_reg] <= new_entry;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (enq) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (enq && !deq) begin
            count_reg <= count_reg + CNT_W'(1);
         end else if (deq && !enq) begin
            count_reg <= count_reg - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wb_valid_reg    <= 1'b0;
         wb_rd_reg       <= '0;
         wb_data_reg     <= '0;
         wb_misalign_reg <= 1'b0;
      end else if (flush_i) begin
         wb_valid_reg <= 1'b0;
      end else if (deq) begin
         wb_valid_reg    <= 1'b1;
         wb_rd_reg       <= head.rd;
         wb_data_reg     <= head.misalign ? '0 : extended;
         wb_misalign_reg <= head.misalign;
      end else if (wb_ready_i) begin
         wb_valid_reg <= 1'b0;
      end
   end

   assign wb_valid_o    = wb_valid_reg;
   assign wb_rd_o       = wb_rd_reg;
   assign wb_data_o     = wb_data_reg;
   assign wb_misalign_o = wb_misalign_reg;

endmodule

// File: tb/tb_lsu_load_aligner.sv
// Directed bench for lsu_load_aligner: request records and response data feed a
// scoreboard that predicts every writeback in issue order.
module tb_lsu_load_aligner;

   logic        clk;
   logic        rstn;
   logic        flush_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  req_offset_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic [5:0]  req_rd_i;
   logic        resp_valid_i;
   logic [63:0] resp_data_i;
   logic        resp_ready_o;
   logic        wb_valid_o;
   logic        wb_ready_i;
   logic [5:0]  wb_rd_o;
   logic [63:0] wb_data_o;
   logic        wb_misalign_o;

   lsu_load_aligner #(.XLEN(64), .DEPTH(4), .PREG_W(6)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .flush_i        (flush_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_offset_i   (req_offset_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_rd_i       (req_rd_i),
      .resp_valid_i   (resp_valid_i),
      .resp_data_i    (resp_data_i),
      .resp_ready_o   (resp_ready_o),
      .wb_valid_o     (wb_valid_o),
      .wb_ready_i     (wb_ready_i),
      .wb_rd_o        (wb_rd_o),
      .wb_data_o      (wb_data_o),
      .wb_misalign_o  (wb_misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] off;
      logic [1:0] size;
      logic       uns;
      logic [5:0] rd;
      logic       mis;
   } rec_t;

   rec_t        model_q[$];
   logic [63:0] resp_src[$];
   logic [63:0] resp_hist[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_resp_f = 0;
   bit          resp_en = 1'b1;
   bit          last_req_f = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic is_mis(input logic [2:0] off, input logic [1:0] sz);
      return (int'(off) % (1 << sz)) != 0;
   endfunction

   // Byte-wise reference extraction, independent of any shift formulation.
   function automatic logic [63:0] align_model(input rec_t r, input logic [63:0] d);
      logic [63:0] v;
      int nb;
      v  = '0;
      nb = 1 << r.size;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = d[8*(int'(r.off)+i) +: 8];
      if (!r.uns && v[8*nb-1]) begin
         for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
      end
      return v;
   endfunction

   task automatic check_wb();
      rec_t        r;
      logic [63:0] exp_d;
      $display("wb rd=%0d data=%h misalign=%0b", wb_rd_o, wb_data_o, wb_misalign_o);
      if (model_q.size() == 0) begin
         chk("wb_pending", 64'(model_q.size()), 64'd1);
         return;
      end
      r = model_q.pop_front();
      if (r.mis) begin
         exp_d = '0;
      end else if (resp_hist.size() == 0) begin
         chk("wb_resp_seen", 64'(resp_hist.size()), 64'd1);
         return;
      end else begin
         exp_d = align_model(r, resp_hist.pop_front());
      end
      chk("wb_rd", 64'(wb_rd_o), 64'(r.rd));
      chk("wb_data", wb_data_o, exp_d);
      chk("wb_misalign", 64'(wb_misalign_o), 64'(r.mis));
   endtask

   // One clock: present the next response, record handshakes before the edge,
   // then return 1 time unit after the rising edge.
   task automatic tick();
      bit   req_f, resp_f, wb_f, fl;
      rec_t r;
      resp_valid_i = resp_en && (resp_src.size() != 0);
      resp_data_i  = (resp_src.size() != 0) ? resp_src[0] : 64'd0;
      #1;
      fl     = flush_i;
      req_f  = req_valid_i && req_ready_o && !flush_i;
      resp_f = resp_valid_i && resp_ready_o;
      wb_f   = wb_valid_o && wb_ready_i;
      if (wb_f) check_wb();
      if (resp_f) begin
         resp_hist.push_back(resp_src.pop_front());
         n_resp_f++;
      end
      if (req_f) begin
         r.off  = req_offset_i;
         r.size = req_size_i;
         r.uns  = req_unsigned_i;
         r.rd   = req_rd_i;
         r.mis  = is_mis(req_offset_i, req_size_i);
         model_q.push_back(r);
      end
      last_req_f = req_f;
      @(posedge clk);
      #1;
      if (fl) begin
         model_q.delete();
         resp_hist.delete();
         resp_src.delete();
      end
   endtask

   task automatic issue(input logic [2:0] off, input logic [1:0] sz, input logic uns,
                        input logic [5:0] rd, input logic [63:0] d);
      int n;
      n              = 0;
      req_valid_i    = 1'b1;
      req_offset_i   = off;
      req_size_i     = sz;
      req_unsigned_i = uns;
      req_rd_i       = rd;
      if (!is_mis(off, sz)) resp_src.push_back(d);
      do begin
         tick();
         n++;
      end while (!last_req_f && n < 20);
      req_valid_i = 1'b0;
      chk("issue_accept", 64'(last_req_f), 64'd1);
   endtask

   task automatic rand_issue(input logic [5:0] rd);
      logic [1:0] sz;
      logic [2:0] m;
      logic [2:0] off;
      sz  = 2'($urandom_range(0, 3));
      m   = 3'((1 << sz) - 1);
      off = 3'($urandom_range(0, 7)) & ~m;
      issue(off, sz, 1'($urandom_range(0, 1)), rd, {$urandom, $urandom});
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (model_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_empty", 64'(model_q.size()), 64'd0);
      chk("drain_resp_left", 64'(resp_src.size() + resp_hist.size()), 64'd0);
   endtask

   task automatic expect_wb(input logic [5:0] rd, input logic [63:0] d, input logic mis);
      int n;
      n = 0;
      while (!wb_valid_o && n < 10) begin
         tick();
         n++;
      end
      chk("exp_wb_valid", 64'(wb_valid_o), 64'd1);
      chk("exp_wb_rd", 64'(wb_rd_o), 64'(rd));
      chk("exp_wb_data", wb_data_o, d);
      chk("exp_wb_misalign", 64'(wb_misalign_o), 64'(mis));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
      chk({tag, "_resp_ready"}, 64'(resp_ready_o), 64'd0);
      chk({tag, "_wb_valid"}, 64'(wb_valid_o), 64'd0);
      chk({tag, "_wb_rd"}, 64'(wb_rd_o), 64'd0);
      chk({tag, "_wb_data"}, wb_data_o, 64'd0);
      chk({tag, "_wb_misalign"}, 64'(wb_misalign_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int resp_before;
      rstn = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_offset_i = '0;
      req_size_i = '0; req_unsigned_i = 1'b0; req_rd_i = '0;
      resp_valid_i = 1'b0; resp_data_i = '0; wb_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Signed byte at offset 5
      issue(3'd5, 2'd0, 1'b0, 6'd7, 64'h0000_80FF_0000_0000);
      #1;
      chk("t1_resp_ready", 64'(resp_ready_o), 64'd1);
      tick();
      expect_wb(6'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
      tick();

      // Unsigned word, then dword of the same data
      issue(3'd4, 2'd2, 1'b1, 6'd8, 64'h8765_4321_0000_0000);
      issue(3'd0, 2'd3, 1'b0, 6'd9, 64'h8765_4321_0000_0000);
      expect_wb(6'd8, 64'h0000_0000_8765_4321, 1'b0);
      tick();
      expect_wb(6'd9, 64'h8765_4321_0000_0000, 1'b0);
      tick();
      drain();

      // Fill without responses, attempt one more, then stream with wrap
      resp_en = 1'b0;
      for (int i = 0; i < 4; i++) rand_issue(6'(16 + i));
      chk("full_req_ready", 64'(req_ready_o), 64'd0);
      req_valid_i = 1'b1; req_offset_i = 3'd0; req_size_i = 2'd3; req_rd_i = 6'd63;
      tick();
      req_valid_i = 1'b0;
      chk("full_depth", 64'(model_q.size()), 64'd4);
      resp_en = 1'b1;
      for (int i = 0; i < 6; i++) rand_issue(6'(24 + i));
      drain();

      // Writeback backpressure holds the output and blocks responses
      issue(3'd0, 2'd3, 1'b0, 6'd10, 64'h1122_3344_5566_7788);
      wb_ready_i = 1'b0;
      issue(3'd0, 2'd2, 1'b0, 6'd11, 64'h0000_0000_8000_0001);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_resp_ready", 64'(resp_ready_o), 64'd0);
         chk("bp_wb_valid", 64'(wb_valid_o), 64'd1);
         chk("bp_wb_rd", 64'(wb_rd_o), 64'd10);
         chk("bp_wb_data", wb_data_o, 64'h1122_3344_5566_7788);
         tick();
      end
      wb_ready_i = 1'b1;
      #1;
      chk("bp_release_resp_ready", 64'(resp_ready_o), 64'd1);
      tick();
      expect_wb(6'd11, 64'hFFFF_FFFF_8000_0001, 1'b0);
      drain();

      // Misaligned half between two aligned loads consumes no response
      resp_before = n_resp_f;
      issue(3'd2, 2'd1, 1'b0, 6'd12, {$urandom, $urandom});
      issue(3'd3, 2'd1, 1'b0, 6'd13, 64'd0);
      issue(3'd4, 2'd2, 1'b0, 6'd14, {$urandom, $urandom});
      drain();
      chk("mis_resp_count", 64'(n_resp_f - resp_before), 64'd2);

      // Flush with a valid output, three pending loads, and concurrent req/resp
      wb_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) rand_issue(6'(20 + i));
      chk("pre_flush_wb_valid", 64'(wb_valid_o), 64'd1);
      resp_before    = n_resp_f;
      flush_i        = 1'b1;
      req_valid_i    = 1'b1;
      req_offset_i   = 3'd0;
      req_size_i     = 2'd3;
      req_rd_i       = 6'd30;
      #1;
      chk("flush_resp_ready", 64'(resp_ready_o), 64'd0);
      tick();
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      chk("flush_wb_valid", 64'(wb_valid_o), 64'd0);
      chk("flush_req_ready", 64'(req_ready_o), 64'd1);
      chk("flush_empty_resp_ready", 64'(resp_ready_o), 64'd0);
      chk("flush_no_resp", 64'(n_resp_f - resp_before), 64'd0);
      wb_ready_i = 1'b1;
      resp_en    = 1'b0;
      for (int i = 0; i < 3; i++) rand_issue(6'(40 + i));
      chk("post_flush_not_full", 64'(req_ready_o), 64'd1);
      rand_issue(6'd43);
      chk("post_flush_full", 64'(req_ready_o), 64'd0);
      resp_en = 1'b1;
      drain();

      // Asynchronous reset in the middle of traffic
      wb_ready_i = 1'b0;
      rand_issue(6'd50);
      rand_issue(6'd51);
      #2;
      rstn = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      model_q.delete();
      resp_src.delete();
      resp_hist.delete();
      @(posedge clk);
      #1;
      rstn       = 1'b1;
      wb_ready_i = 1'b1;
      issue(3'd6, 2'd1, 1'b1, 6'd52, 64'hBEEF_0000_0000_0000);
      expect_wb(6'd52, 64'h0000_0000_0000_BEEF, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
